// File: rtl/nmos_pmos.sv
// ============================================================================
// nmos_pmos : registered 4-state nMOS/pMOS switch pair evaluator, N lanes
// Rev 1.0
// ============================================================================
`default_nettype none

module nmos_pmos #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  input  logic [2*N-1:0] ngate,
  input  logic [2*N-1:0] nsrc,
  input  logic [2*N-1:0] pgate,
  input  logic [2*N-1:0] psrc,
  output logic           out_valid,
  output logic [2*N-1:0] n_drain,
  output logic [2*N-1:0] p_drain,
  output logic [2*N-1:0] drain,
  output logic [N-1:0]   contention
);

  localparam logic [1:0] C_L0 = 2'b00;
  localparam logic [1:0] C_L1 = 2'b01;
  localparam logic [1:0] C_LZ = 2'b10;
  localparam logic [1:0] C_LX = 2'b11;

  // on_lvl is the gate level that closes the switch (1 for nMOS, 0 for pMOS).
  function automatic logic [1:0] f_switch(input logic [1:0] gate,
                                          input logic [1:0] src,
                                          input logic       on_lvl);
    logic [1:0] res;
    if (gate == {1'b0, on_lvl}) begin
      res = src;
    end else if (gate == {1'b0, ~on_lvl}) begin
      res = C_LZ;
    end else begin
      res = (src == C_LZ) ? C_LZ : C_LX;
    end
    return res;
  endfunction

  function automatic logic [1:0] f_resolve(input logic [1:0] a,
                                           input logic [1:0] b);
    logic [1:0] res;
    if (a == C_LZ) begin
      res = b;
    end else if (b == C_LZ) begin
      res = a;
    end else if (a == b) begin
      res = a;
    end else begin
      res = C_LX;
    end
    return res;
  endfunction

  function automatic logic f_fight(input logic [1:0] a,
                                   input logic [1:0] b);
    return ((a == C_L0) && (b == C_L1)) || ((a == C_L1) && (b == C_L0));
  endfunction

  logic [2*N-1:0] n_drain_d;
  logic [2*N-1:0] p_drain_d;
  logic [2*N-1:0] drain_d;
  logic [N-1:0]   contention_d;

  logic           out_valid_q;
  logic [2*N-1:0] n_drain_q;
  logic [2*N-1:0] p_drain_q;
  logic [2*N-1:0] drain_q;
  logic [N-1:0]   contention_q;

  for (genvar i = 0; i < N; i++) begin : g_lane
    assign n_drain_d[2*i +: 2] = f_switch(ngate[2*i +: 2], nsrc[2*i +: 2], 1'b1);
    assign p_drain_d[2*i +: 2] = f_switch(pgate[2*i +: 2], psrc[2*i +: 2], 1'b0);
    assign drain_d[2*i +: 2]   = f_resolve(n_drain_d[2*i +: 2], p_drain_d[2*i +: 2]);
    assign contention_d[i]     = f_fight(n_drain_d[2*i +: 2], p_drain_d[2*i +: 2]);
  end

  // Data registers only load on valid input so results hold across idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      n_drain_q    <= {N{C_LZ}};
      p_drain_q    <= {N{C_LZ}};
      drain_q      <= {N{C_LZ}};
      contention_q <= '0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        n_drain_q    <= n_drain_d;
        p_drain_q    <= p_drain_d;
        drain_q      <= drain_d;
        contention_q <= contention_d;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign n_drain    = n_drain_q;
  assign p_drain    = p_drain_q;
  assign drain      = drain_q;
  assign contention = contention_q;

endmodule

`default_nettype wire

// File: tb/tb_nmos_pmos.sv
// ============================================================================
// tb_nmos_pmos : directed self-checking bench for nmos_pmos (N=4)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_nmos_pmos;

  localparam int N = 4;
  localparam logic [1:0] L0 = 2'b00;
  localparam logic [1:0] L1 = 2'b01;
  localparam logic [1:0] LZ = 2'b10;
  localparam logic [1:0] LX = 2'b11;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           in_valid = 1'b0;
  logic [2*N-1:0] ngate = '0;
  logic [2*N-1:0] nsrc = '0;
  logic [2*N-1:0] pgate = '0;
  logic [2*N-1:0] psrc = '0;
  logic           out_valid;
  logic [2*N-1:0] n_drain;
  logic [2*N-1:0] p_drain;
  logic [2*N-1:0] drain;
  logic [N-1:0]   contention;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  nmos_pmos #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .ngate     (ngate),
    .nsrc      (nsrc),
    .pgate     (pgate),
    .psrc      (psrc),
    .out_valid (out_valid),
    .n_drain   (n_drain),
    .p_drain   (p_drain),
    .drain     (drain),
    .contention(contention)
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input logic [1:0] ng, input logic [1:0] ns,
                          input logic [1:0] pg, input logic [1:0] ps);
    ngate[2*i +: 2] = ng;
    nsrc[2*i +: 2]  = ns;
    pgate[2*i +: 2] = pg;
    psrc[2*i +: 2]  = ps;
  endtask

  task automatic test_reset();
    ngate = 8'h5A; nsrc = 8'hC3; pgate = 8'h96; psrc = 8'h3C; in_valid = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (n_drain !== 8'hAA) begin failures++; $display("FAIL reset_n_drain got=%h exp=aa", n_drain); end
    checks++; if (p_drain !== 8'hAA) begin failures++; $display("FAIL reset_p_drain got=%h exp=aa", p_drain); end
    checks++; if (drain !== 8'hAA) begin failures++; $display("FAIL reset_drain got=%h exp=aa", drain); end
    checks++; if (contention !== 4'h0) begin failures++; $display("FAIL reset_contention got=%b exp=0000", contention); end
    in_valid = 1'b0;
    cycle();
    @(negedge clk) rst_n = 1'b1;
    cycle();
    checks++; if (drain !== 8'hAA || out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_hold drain=%h ov=%b exp aa/0", drain, out_valid); end
  endtask

  task automatic test_inverter();
    logic [1:0] ins [4];
    logic [1:0] exp_d [4];
    ins[0] = L0; ins[1] = L1; ins[2] = LX; ins[3] = LZ;
    exp_d[0] = L1; exp_d[1] = L0; exp_d[2] = LX; exp_d[3] = LX;
    for (int i = 0; i < N; i++) set_lane(i, ins[i], L0, ins[i], L1);
    in_valid = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || drain !== 8'hAA) begin
      failures++; $display("FAIL inv_latency ov=%b drain=%h exp 0/aa", out_valid, drain); end
    cycle();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL inv_out_valid got=%b exp=1", out_valid); end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (drain[2*i +: 2] !== exp_d[i]) begin
        failures++; $display("FAIL inv_drain lane%0d got=%b exp=%b", i, drain[2*i +: 2], exp_d[i]);
      end
    end
    checks++; if (n_drain !== {LX, LX, L0, LZ}) begin failures++; $display("FAIL inv_n_drain got=%h exp=%h", n_drain, {LX, LX, L0, LZ}); end
    checks++; if (p_drain !== {LX, LX, LZ, L1}) begin failures++; $display("FAIL inv_p_drain got=%h exp=%h", p_drain, {LX, LX, LZ, L1}); end
    checks++; if (contention !== 4'b0000) begin failures++; $display("FAIL inv_contention got=%b exp=0000", contention); end
  endtask

  task automatic test_pass_off();
    set_lane(0, L1, LZ, L1, L0);
    set_lane(1, L0, L1, L1, L0);
    set_lane(2, L0, L0, LZ, LZ);
    set_lane(3, L0, L0, LZ, L0);
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    checks++; if (n_drain !== 8'hAA) begin failures++; $display("FAIL pass_n_drain got=%h exp=aa", n_drain); end
    checks++; if (p_drain !== 8'hEA) begin failures++; $display("FAIL pass_p_drain got=%h exp=ea", p_drain); end
    checks++; if (drain !== 8'hEA) begin failures++; $display("FAIL pass_drain got=%h exp=ea", drain); end
    checks++; if (contention !== 4'b0000) begin failures++; $display("FAIL pass_contention got=%b exp=0000", contention); end
  endtask

  task automatic test_contention();
    set_lane(0, L1, L0, L0, L1);
    set_lane(1, L1, L1, L0, L1);
    set_lane(2, LX, L1, L0, L0);
    set_lane(3, L1, L1, L0, L0);
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    checks++; if (drain !== {LX, LX, L1, LX}) begin failures++; $display("FAIL cont_drain got=%h exp=%h", drain, {LX, LX, L1, LX}); end
    checks++; if (contention !== 4'b1001) begin failures++; $display("FAIL cont_flags got=%b exp=1001", contention); end
    checks++; if (n_drain !== {L1, LX, L1, L0}) begin failures++; $display("FAIL cont_n_drain got=%h exp=%h", n_drain, {L1, LX, L1, L0}); end
    checks++; if (p_drain !== {L0, L0, L1, L1}) begin failures++; $display("FAIL cont_p_drain got=%h exp=%h", p_drain, {L0, L0, L1, L1}); end
  endtask

  task automatic test_nand();
    logic [1:0] mid;
    logic [1:0] exp_mid;
    logic [1:0] exp_out;
    for (int ab = 0; ab < 4; ab++) begin
      logic a;
      logic b;
      a = ab[1];
      b = ab[0];
      exp_mid = a ? L0 : LZ;
      exp_out = (a && b) ? L0 : LZ;
      ngate = '0; nsrc = '0; pgate = {N{L1}}; psrc = '0;
      set_lane(0, {1'b0, a}, L0, L1, L0);
      in_valid = 1'b1;
      cycle();
      mid = n_drain[1:0];
      checks++; if (mid !== exp_mid) begin failures++; $display("FAIL nand_stage0 a=%b got=%b exp=%b", a, mid, exp_mid); end
      set_lane(1, {1'b0, b}, mid, L1, L0);
      cycle();
      in_valid = 1'b0;
      checks++; if (n_drain[3:2] !== exp_out) begin
        failures++; $display("FAIL nand_stage1 a=%b b=%b got=%b exp=%b", a, b, n_drain[3:2], exp_out); end
    end
  endtask

  task automatic test_hold_valid();
    for (int i = 0; i < N; i++) set_lane(i, {1'b0, i[0]}, L0, {1'b0, i[0]}, L1);
    in_valid = 1'b1;
    cycle();
    checks++; if (out_valid !== 1'b1 || drain !== 8'h11) begin
      failures++; $display("FAIL hold_first ov=%b drain=%h exp 1/11", out_valid, drain); end
    for (int i = 0; i < N; i++) set_lane(i, LX, L0, LX, L1);
    in_valid = 1'b0;
    cycle();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL hold_idle_valid got=%b exp=0", out_valid); end
    checks++; if (drain !== 8'h11 || n_drain !== 8'h22 || p_drain !== 8'h99) begin
      failures++; $display("FAIL hold_idle_data drain=%h n=%h p=%h exp 11/22/99", drain, n_drain, p_drain); end
    for (int i = 0; i < N; i++) set_lane(i, {1'b0, ~i[0]}, L0, {1'b0, ~i[0]}, L1);
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || drain !== 8'h44) begin
      failures++; $display("FAIL hold_third ov=%b drain=%h exp 1/44", out_valid, drain); end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < N; i++) set_lane(i, L1, L1, L1, L0);
    in_valid = 1'b1;
    cycle();
    checks++; if (drain !== 8'h55) begin failures++; $display("FAIL midrst_pre drain=%h exp=55", drain); end
    for (int i = 0; i < N; i++) set_lane(i, L0, L0, L0, L0);
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || drain !== 8'hAA || contention !== 4'b0) begin
      failures++; $display("FAIL midrst_async ov=%b drain=%h cont=%b exp 0/aa/0", out_valid, drain, contention); end
    cycle();
    @(negedge clk) rst_n = 1'b1;
    in_valid = 1'b0;
    cycle();
    checks++; if (out_valid !== 1'b0 || drain !== 8'hAA || n_drain !== 8'hAA) begin
      failures++; $display("FAIL midrst_after ov=%b drain=%h n=%h exp 0/aa/aa", out_valid, drain, n_drain); end
    for (int i = 0; i < N; i++) set_lane(i, L0, L0, L0, L1);
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || drain !== 8'h55 || p_drain !== 8'h55 || n_drain !== 8'hAA) begin
      failures++; $display("FAIL midrst_resume ov=%b drain=%h p=%h n=%h exp 1/55/55/aa", out_valid, drain, p_drain, n_drain); end
  endtask

  initial begin
    test_reset();
    test_inverter();
    test_pass_off();
    test_contention();
    test_nand();
    test_hold_valid();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/nmos_pmos.md
Name: nmos_pmos

Overview:
- Clocked, registered switch-level evaluator for N independent complementary MOS pairs, each one nMOS and one pMOS switch.
- Each cycle it takes 4-state gate and source values per lane and computes the nMOS drain, the pMOS drain and the wired (shared-drain) resolution of the two.
- Used as the transistor-level cell model inside the gate-library verification harness (inverter/NAND/NOR building blocks).

Parameters:
N, 4, number of independent transistor-pair lanes (1..32)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  lane inputs valid this cycle
ngate  input  2*N  nMOS gate value per lane, lane i at [2i+1:2i]
nsrc  input  2*N  nMOS source value per lane
pgate  input  2*N  pMOS gate value per lane
psrc  input  2*N  pMOS source value per lane
out_valid  output  1  registered in_valid
n_drain  output  2*N  nMOS drain value per lane
p_drain  output  2*N  pMOS drain value per lane
drain  output  2*N  resolved shared-drain value per lane
contention  output  N  per lane: both switches drive opposite strong levels

Behaviour:
- 4-state encoding, all 2-bit fields: 00=0, 01=1, 10=Z, 11=X.
- nMOS switch function, combinational per lane:
  - ngate=1: drain=nsrc.
  - ngate=0: drain=Z.
  - ngate X or Z: drain=Z if nsrc=Z, else X.
- pMOS switch function: identical, but conducts on pgate=0 and is off (Z) on pgate=1.
- Wired resolution of n and p drains:
  - Z with v gives v; equal values give that value.
  - 0 with 1 gives X and sets contention.
  - Any X gives X; contention stays 0 unless the 0/1 case applies.
- No strength modelling: weak L/H levels collapse to X.
- Timing: all outputs registered, latency exactly 1 cycle.
  - When in_valid=1 at a rising edge, the outputs update on that edge and out_valid=1.
  - When in_valid=0, out_valid=0 and the data outputs hold their previous values.
- Reset: rst_n low asynchronously forces out_valid=0, every drain lane to Z (10), and contention to all 0. Outputs stay there until the first valid edge after rst_n rises.
  - Reset asserted mid-stream discards the pending result.
- Lanes are fully independent; no cross-lane interaction.
- No handshake back-pressure; a new input is accepted every cycle.

Test Plan:
- Reset: assert rst_n=0 with arbitrary inputs -> out_valid=0, n_drain=p_drain=drain all lanes 10, contention=0, all immediately without a clock edge.
- Inverter lane (psrc=1, nsrc=0, pgate=ngate=in):
  - in=0 -> drain=1.
  - in=1 -> drain=0.
  - in=X -> drain=X, contention=0.
  - Each result appears one cycle after the valid input.
- Pass/off: ngate=1, nsrc=Z -> n_drain=Z. ngate=0, nsrc=1 -> n_drain=Z. pgate=Z, psrc=Z -> p_drain=Z. pgate=Z, psrc=0 -> p_drain=X.
- Contention: pgate=0, psrc=1, ngate=1, nsrc=0 -> drain=X, contention=1. Same with nsrc=1 -> drain=1, contention=0.
- NAND pull-down series emulation with N=2:
  - Lane0: ngate=a, nsrc=0.
  - Feed lane0 n_drain into lane1 nsrc one cycle later, with lane1 ngate=b.
  - Exhaust all four (a,b) combinations: lane1 n_drain=0 only for a=b=1, else Z.
- Hold/valid: alternate in_valid 1,0,1 with changing data -> out_valid 1,0,1 delayed one cycle. Data is unchanged across the in_valid=0 cycle.
- Mid-stream reset: pulse rst_n low between two valid inputs -> outputs return to Z/0 and out_valid=0 on the cycle after reset. The next valid input is processed normally.
